// File: rtl/lockin_pkg.sv
// Shared types, defaults and helpers for the lock-in I/Q demodulator.
// LOCKIN_SATURATE_EN selects the output clamp helper in lockin_mac.
package lockin_pkg;

  localparam int unsigned BIT_WIDTH_DEF = 24;
  localparam int unsigned LOG2_N_DEF    = 10;

  typedef enum logic {
    READY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned log2n);
    return 2 * bw + log2n;
  endfunction

  // Clamp a sign-extended value into a signed bw-bit range (bw <= 63).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned       bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lockin_mac.sv
// One multiply/accumulate/convert channel: S1 product, S2 accumulate, block
// capture and output conversion. LOCKIN_SATURATE_EN clamps instead of wrapping.
module lockin_mac
  import lockin_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int unsigned LOG2_N    = LOG2_N_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_adc,
  input  logic [BIT_WIDTH-1:0] i_ref,
  input  logic                 i_blk_end,
  output logic                 o_s2_valid,
  output logic                 o_blk_valid,
  output logic [BIT_WIDTH-1:0] o_result
);

  localparam int unsigned ACC_W  = acc_width(BIT_WIDTH, LOG2_N);
  localparam int unsigned PROD_W = 2 * BIT_WIDTH;
  localparam int unsigned SHIFT  = LOG2_N + BIT_WIDTH - 1;
`ifdef LOCKIN_SATURATE_EN
  localparam int unsigned BLK_W  = BIT_WIDTH + 1;
`else
  localparam int unsigned BLK_W  = BIT_WIDTH;
`endif

  logic signed [PROD_W-1:0] r_prod;
  logic                     r_s1_valid;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [BLK_W-1:0]  r_blk;
  logic                     r_blk_valid;
  logic signed [ACC_W-1:0]  w_sum;

  assign w_sum = r_acc + ACC_W'(r_prod);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prod      <= '0;
      r_s1_valid  <= 1'b0;
      r_acc       <= '0;
      r_blk       <= '0;
      r_blk_valid <= 1'b0;
    end else begin
      r_s1_valid  <= i_valid;
      r_blk_valid <= r_s1_valid & i_blk_end;
      if (i_valid)
        r_prod <= PROD_W'($signed(i_adc)) * PROD_W'($signed(i_ref));
      // Only the bits that survive the >>> SHIFT conversion are kept per block.
      if (r_s1_valid) begin
        if (i_blk_end) begin
          r_blk <= w_sum[SHIFT +: BLK_W];
          r_acc <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign o_s2_valid  = r_s1_valid;
  assign o_blk_valid = r_blk_valid;

`ifdef LOCKIN_SATURATE_EN
  assign o_result = BIT_WIDTH'(sat_clamp(64'(r_blk), BIT_WIDTH));
`else
  assign o_result = r_blk;
`endif

endmodule

// File: rtl/lockin_iq_demod.sv
// Lock-in I/Q demodulator: averages adc*ref_sin/ref_cos over 2^LOG2_N samples and
// hands each block to the CORDIC. LOCKIN_SATURATE_EN enables output clamping.
module lockin_iq_demod
  import lockin_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int unsigned LOG2_N    = LOG2_N_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sample_valid_i,
  input  logic [BIT_WIDTH-1:0] adc_i,
  input  logic [BIT_WIDTH-1:0] ref_sin_i,
  input  logic [BIT_WIDTH-1:0] ref_cos_i,
  input  logic                 cordic_done_i,
  output logic [BIT_WIDTH-1:0] sin_o,
  output logic [BIT_WIDTH-1:0] cos_o,
  output logic                 start_o,
  output logic                 overrun_o
);

  state_t               r_state, w_state_nx;
  logic [LOG2_N-1:0]    r_cnt;
  logic                 w_blk_end;
  logic                 w_s2_valid_s, w_s2_valid_c, w_s2_valid;
  logic                 w_blk_valid_s, w_blk_valid_c, w_blk_valid;
  logic [BIT_WIDTH-1:0] w_res_s, w_res_c;
  logic                 w_accept, w_drop;

  assign w_blk_end   = (r_cnt == '1);
  assign w_s2_valid  = w_s2_valid_s & w_s2_valid_c;
  assign w_blk_valid = w_blk_valid_s & w_blk_valid_c;

  lockin_mac #(.BIT_WIDTH(BIT_WIDTH), .LOG2_N(LOG2_N)) u_mac_sin (
    .i_clk(clk_i), .i_reset(reset_i), .i_valid(sample_valid_i),
    .i_adc(adc_i), .i_ref(ref_sin_i), .i_blk_end(w_blk_end),
    .o_s2_valid(w_s2_valid_s), .o_blk_valid(w_blk_valid_s), .o_result(w_res_s)
  );

  lockin_mac #(.BIT_WIDTH(BIT_WIDTH), .LOG2_N(LOG2_N)) u_mac_cos (
    .i_clk(clk_i), .i_reset(reset_i), .i_valid(sample_valid_i),
    .i_adc(adc_i), .i_ref(ref_cos_i), .i_blk_end(w_blk_end),
    .o_s2_valid(w_s2_valid_c), .o_blk_valid(w_blk_valid_c), .o_result(w_res_c)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)         r_cnt <= '0;
    else if (w_s2_valid) r_cnt <= r_cnt + LOG2_N'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= READY;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      READY:   if (w_blk_valid) w_state_nx = BUSY;
      BUSY:    if (!w_blk_valid && cordic_done_i) w_state_nx = READY;
      default: w_state_nx = READY;
    endcase
  end

  // A block arriving with the done pulse is taken; the CORDIC restarts on it.
  always_comb begin
    w_accept = w_blk_valid & ((r_state == READY) | cordic_done_i);
    w_drop   = w_blk_valid & (r_state == BUSY) & ~cordic_done_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sin_o     <= '0;
      cos_o     <= '0;
      start_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      start_o <= w_accept;
      if (w_accept) begin
        sin_o <= w_res_s;
        cos_o <= w_res_c;
      end
      if (w_drop) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lockin_iq_demod.sv
// Self-checking bench for lockin_iq_demod (LOG2_N=4, BIT_WIDTH=24); honours
// LOCKIN_SATURATE_EN in its reference model.
module tb_lockin_iq_demod;

  localparam int BW = 24;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          reset_i, sample_valid_i, cordic_done_i;
  logic [BW-1:0] adc_i, ref_sin_i, ref_cos_i;
  logic [BW-1:0] sin_o, cos_o;
  logic          start_o, overrun_o;

  int tests = 0;
  int fails = 0;
  int k = 0;

  // Reference model state
  bit            m_busy, m_start, m_ovr, auto_done;
  logic [BW-1:0] m_sin, m_cos;
  longint        m_sq, m_si;
  int            m_cnt;
  int            pend_due[$];
  logic [BW-1:0] pend_q[$], pend_i[$];

  lockin_iq_demod #(.BIT_WIDTH(BW), .LOG2_N(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .sample_valid_i(sample_valid_i),
    .adc_i(adc_i), .ref_sin_i(ref_sin_i), .ref_cos_i(ref_cos_i),
    .cordic_done_i(cordic_done_i), .sin_o(sin_o), .cos_o(cos_o),
    .start_o(start_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Average of N products in Q1.23, floor-rounded: sum / 16 / 2^23.
  function automatic logic [BW-1:0] conv(input longint s);
    longint r;
    r = s >>> 27;
`ifdef LOCKIN_SATURATE_EN
    if (r > 64'sd8388607)       r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
`endif
    return r[BW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("start_o",   {23'b0, start_o},   {23'b0, m_start});
    chk("overrun_o", {23'b0, overrun_o}, {23'b0, m_ovr});
    chk("sin_o", sin_o, m_sin);
    chk("cos_o", cos_o, m_cos);
  endtask

  task automatic model_reset();
    m_busy = 0; m_start = 0; m_ovr = 0;
    m_sin = '0; m_cos = '0;
    m_sq = 0; m_si = 0; m_cnt = 0;
    pend_due.delete(); pend_q.delete(); pend_i.delete();
  endtask

  task automatic step(input bit v, input logic [BW-1:0] a, input logic [BW-1:0] rs,
                      input logic [BW-1:0] rc, input bit d);
    bit blk, dn;
    logic [BW-1:0] bq, bi;
    blk = 0; bq = '0; bi = '0;
    if (pend_due.size() > 0 && pend_due[0] == k) begin
      blk = 1; bq = pend_q.pop_front(); bi = pend_i.pop_front();
      void'(pend_due.pop_front());
    end
    dn = d | (auto_done & blk);
    sample_valid_i = v; adc_i = a; ref_sin_i = rs; ref_cos_i = rc; cordic_done_i = dn;
    m_start = 0;
    if (blk) begin
      if (!m_busy || dn) begin
        m_sin = bq; m_cos = bi; m_start = 1; m_busy = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (dn) begin
      m_busy = 0;
    end
    if (v) begin
      m_sq += longint'($signed(a)) * longint'($signed(rs));
      m_si += longint'($signed(a)) * longint'($signed(rc));
      m_cnt++;
      if (m_cnt == NS) begin
        pend_due.push_back(k + 2);
        pend_q.push_back(conv(m_sq));
        pend_i.push_back(conv(m_si));
        m_sq = 0; m_si = 0; m_cnt = 0;
      end
    end
    @(posedge clk); #1;
    check_all();
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0);
  endtask

  task automatic done_pulse();
    step(0, '0, '0, '0, 1);
  endtask

  task automatic feed_block(input logic [BW-1:0] a, input logic [BW-1:0] rs,
                            input logic [BW-1:0] rc, input int gap);
    for (int i = 0; i < NS; i++) begin
      step(1, a, rs, rc, 0);
      idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    reset_i = 1; sample_valid_i = 0; cordic_done_i = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k++;
    end
    model_reset();
    check_all();
    reset_i = 0;
  endtask

  initial begin
    logic [BW-1:0] ra, rs, rc;
    reset_i = 1; sample_valid_i = 0; cordic_done_i = 0;
    adc_i = '0; ref_sin_i = '0; ref_cos_i = '0; auto_done = 0;
    model_reset();
    do_reset(3);

    // Half-scale ADC against full-scale cosine
    feed_block(24'h400000, 24'h000000, 24'h7FFFFF, 0);
    idle(4);
    done_pulse(); idle(2);

    // Negative sine reference
    feed_block(24'h200000, 24'hC00000, 24'h400000, 0);
    idle(4);
    done_pulse(); idle(2);

    // (-1)*(-1): saturates or wraps depending on the build
    feed_block(24'h800000, 24'h800000, 24'h000000, 0);
    idle(4);
    done_pulse(); idle(2);

    // Back-to-back blocks without done: second is dropped, then recovery
    feed_block(24'h100000, 24'h7FFFFF, 24'h200000, 0);
    feed_block(24'h300000, 24'h123456, 24'hE00000, 0);
    idle(4);
    done_pulse(); idle(1);
    feed_block(24'hF00000, 24'h400000, 24'hA00000, 0);
    idle(4);

    // Sparse valids and done coincident with block-complete
    do_reset(1);
    feed_block(24'h400000, 24'h000000, 24'h7FFFFF, 2);
    idle(4);
    auto_done = 1;
    feed_block(24'h400000, 24'h000000, 24'h7FFFFF, 2);
    idle(4);
    auto_done = 0;
    done_pulse(); idle(1);
    done_pulse(); idle(1);
    feed_block(24'hC00000, 24'h7FFFFF, 24'h333333, 0);
    idle(4);

    // Reset mid-block discards partial sums
    for (int i = 0; i < 7; i++) begin
      ra = 24'($urandom); rs = 24'($urandom); rc = 24'($urandom);
      step(1, ra, rs, rc, 0);
    end
    do_reset(1);
    feed_block(24'h400000, 24'h000000, 24'h7FFFFF, 0);
    idle(4);

    // Randomized blocks, gaps and done pulses
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NS; i++) begin
        ra = 24'($urandom); rs = 24'($urandom); rc = 24'($urandom);
        step(1, ra, rs, rc, $urandom_range(0, 3) == 0);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          step(0, '0, '0, '0, $urandom_range(0, 3) == 0);
      end
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
